// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the integer clock divider.
package clk_div_pkg;
    localparam int RATIO_WIDTH_DEF = 3;
    localparam int LEN_W = 16;

    // Low-phase length for ratio n: the low phase takes the extra cycle on odd ratios.
    function automatic logic [LEN_W-1:0] low_len(input logic [LEN_W-1:0] n);
        return (n + LEN_W'(1)) >> 1;
    endfunction
endpackage

// File: rtl/clk_div_if.sv
// Control and output bundle of the clock divider, plus counter observation signals.
interface clk_div_if
    import clk_div_pkg::*;
#(
    parameter int RATIO_WIDTH = RATIO_WIDTH_DEF
);
    logic                   i_clk_en;
    logic [RATIO_WIDTH-1:0] i_div_ratio;
    logic                   o_div_clk;
    logic [RATIO_WIDTH-1:0] dbg_cnt;
    logic                   dbg_wrap;

    // No handshake: i_clk_en / i_div_ratio are level controls sampled every ref edge;
    // o_div_clk is continuous. dbg_* mirror the period counter for checkers.
    modport master (
        output i_clk_en, i_div_ratio,
        input  o_div_clk, dbg_cnt, dbg_wrap
    );
    modport slave (
        input  i_clk_en, i_div_ratio,
        output o_div_clk, dbg_cnt, dbg_wrap
    );
endinterface

// File: rtl/clk_div_counter.sv
// Period counter and ratio latch; the ratio only reloads at a period boundary while running.
module clk_div_counter
    import clk_div_pkg::*;
#(
    parameter int RATIO_WIDTH = RATIO_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_en,
    input  logic [RATIO_WIDTH-1:0] div_ratio,
    output logic [RATIO_WIDTH-1:0] cnt,
    output logic [RATIO_WIDTH-1:0] ratio_q,
    output logic                   wrap
);
    logic [RATIO_WIDTH:0] cnt_x;
    logic [RATIO_WIDTH:0] ratio_x;
    logic                 ratio_ok;
    logic                 run;

    // One extra bit so the all-ones ratio compares without overflow.
    assign cnt_x    = {1'b0, cnt};
    assign ratio_x  = {1'b0, ratio_q};
    assign ratio_ok = ratio_x >= (RATIO_WIDTH+1)'(2);
    assign wrap     = run & clk_en & ratio_ok & (cnt_x == ratio_x - (RATIO_WIDTH+1)'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            ratio_q <= '0;
            run     <= 1'b0;
        end else if (!clk_en || !ratio_ok) begin
            cnt     <= '0;
            ratio_q <= div_ratio;
            run     <= 1'b0;
        end else begin
            run <= 1'b1;
            if (wrap) begin
                cnt     <= '0;
                ratio_q <= div_ratio;
            end else begin
                cnt <= cnt + RATIO_WIDTH'(1);
            end
        end
    end
endmodule

// File: rtl/clk_div.sv
// Programmable integer clock divider (ratio 2..2^W-1) with reference-clock bypass.
module clk_div
    import clk_div_pkg::*;
#(
    parameter int RATIO_WIDTH = RATIO_WIDTH_DEF
) (
    input  logic     i_ref_clk,
    input  logic     i_rst,
    clk_div_if.slave bus
);
    logic [RATIO_WIDTH-1:0] cnt;
    logic [RATIO_WIDTH-1:0] ratio_q;
    logic                   wrap;
    logic                   div_q;
    logic                   active;
    logic [RATIO_WIDTH:0]   lo_len;

    clk_div_counter #(.RATIO_WIDTH(RATIO_WIDTH)) u_counter (
        .clk       (i_ref_clk),
        .rst       (i_rst),
        .clk_en    (bus.i_clk_en),
        .div_ratio (bus.i_div_ratio),
        .cnt       (cnt),
        .ratio_q   (ratio_q),
        .wrap      (wrap)
    );

    assign lo_len = (RATIO_WIDTH+1)'(low_len(LEN_W'(ratio_q)));
    assign active = bus.i_clk_en & ({1'b0, ratio_q} >= (RATIO_WIDTH+1)'(2));

    // Count value 0 opens every period low; reaching the low-phase length turns it high.
    always_ff @(posedge i_ref_clk) begin
        if (i_rst || !active) begin
            div_q <= 1'b0;
        end else if (cnt == '0) begin
            div_q <= 1'b0;
        end else if ({1'b0, cnt} == lo_len) begin
            div_q <= 1'b1;
        end
    end

    assign bus.o_div_clk = active ? div_q : i_ref_clk;
    assign bus.dbg_cnt   = cnt;
    assign bus.dbg_wrap  = wrap;
endmodule

// File: tb/tb_clk_div.sv
// Self-checking bench for clk_div: table of ratio/enable cases plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_clk_div;
  localparam int RW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #2.5 clk = ~clk;

  clk_div_if #(.RATIO_WIDTH(RW)) bus();

  clk_div #(.RATIO_WIDTH(RW)) dut (
    .i_ref_clk (clk),
    .i_rst     (rst),
    .bus       (bus)
  );

  // ---------------- vectors / scoreboard ----------------
  typedef struct {
    string         name;
    logic          en;
    logic [RW-1:0] ratio;
    logic          bypass;
    int            lo;
    int            hi;
    int            periods;
  } vec_t;

  vec_t       vecs[9];
  logic [7:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic       cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic sample();
    @(negedge clk);
    #1;
    cur = bus.o_div_clk;
  endtask

  task automatic run_len(input logic level, output int len);
    len = 0;
    while (cur === level && len < 64) begin
      len++;
      sample();
    end
  endtask

  task automatic measure(input string name, input int lo, input int hi, input int periods);
    int l, h;
    for (int p = 0; p < periods; p++) begin
      exp_q.push_back({4'(lo), 4'(hi)});
      run_len(1'b0, l);
      run_len(1'b1, h);
      check(name, {24'd0, 4'(l), 4'(h)}, {24'd0, exp_q.pop_front()});
    end
  endtask

  task automatic check_bypass(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check(name, 32'(bus.o_div_clk), 32'd1);
      @(negedge clk);
      #1;
      check(name, 32'(bus.o_div_clk), 32'd0);
    end
  endtask

  // Disable, load ratio, then enable; returns with cur holding the sample after edge E.
  task automatic start_div(input logic [RW-1:0] r);
    @(negedge clk);
    bus.i_clk_en    = 1'b0;
    bus.i_div_ratio = r;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.i_clk_en = 1'b1;
    @(posedge clk);
    sample();
  endtask

  // ---------------- test ----------------
  initial begin
    int l, h, rises;
    logic prev;

    vecs[0] = '{"r5",        1'b1, 3'd5, 1'b0, 3, 2, 4};
    vecs[1] = '{"r4",        1'b1, 3'd4, 1'b0, 2, 2, 10};
    vecs[2] = '{"r6",        1'b1, 3'd6, 1'b0, 3, 3, 10};
    vecs[3] = '{"r7",        1'b1, 3'd7, 1'b0, 4, 3, 20};
    vecs[4] = '{"r2",        1'b1, 3'd2, 1'b0, 1, 1, 5};
    vecs[5] = '{"r3",        1'b1, 3'd3, 1'b0, 2, 1, 5};
    vecs[6] = '{"r0_bypass", 1'b1, 3'd0, 1'b1, 0, 0, 0};
    vecs[7] = '{"r1_bypass", 1'b1, 3'd1, 1'b1, 0, 0, 0};
    vecs[8] = '{"en0_bypass",1'b0, 3'd5, 1'b1, 0, 0, 0};

    rst             = 1'b1;
    bus.i_clk_en    = 1'b0;
    bus.i_div_ratio = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_bypass", 32'(bus.o_div_clk), 32'd1);
    check("reset_cnt", 32'(bus.dbg_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].bypass) begin
        @(negedge clk);
        bus.i_clk_en    = vecs[i].en;
        bus.i_div_ratio = vecs[i].ratio;
        repeat (2) @(posedge clk);
        check_bypass(vecs[i].name, 6);
      end else begin
        start_div(vecs[i].ratio);
        measure(vecs[i].name, vecs[i].lo, vecs[i].hi, vecs[i].periods);
      end
    end

    // Ratio 5: four rising edges in the 100 ns after enable.
    start_div(3'd5);
    rises = 0;
    prev  = cur;
    for (int s = 1; s < 20; s++) begin
      sample();
      if (!prev && cur) rises++;
      prev = cur;
    end
    check("r5_rises_100ns", 32'(rises), 32'd4);

    // Ratio 4 -> 7 requested during the high phase: current period finishes first.
    start_div(3'd4);
    run_len(1'b0, l);
    check("r4_low_before_change", 32'(l), 32'd2);
    bus.i_div_ratio = 3'd7;
    run_len(1'b1, h);
    check("r4_high_completes", 32'(h), 32'd2);
    measure("r7_after_change", 4, 3, 2);

    // One-cycle reset in the middle of a ratio-3 period.
    start_div(3'd3);
    measure("r3_pre_reset", 2, 1, 2);
    sample();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_bypass_high", 32'(bus.o_div_clk), 32'd1);
    @(negedge clk);
    #1;
    check("rst_bypass_low", 32'(bus.o_div_clk), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("release_cnt", 32'(bus.dbg_cnt), 32'd0);
    check("release_active_low", 32'(bus.o_div_clk), 32'd0);
    @(posedge clk);
    sample();
    measure("r3_after_reset", 2, 1, 3);

    // Enable falling mid-operation returns to bypass.
    bus.i_clk_en = 1'b0;
    check_bypass("en_fall_bypass", 3);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
